// File: rtl/cart_mbc1.sv
// MBC1 cartridge mapper: bank registers, ROM/RAM address translation and a
// request/acknowledge bridge from the console bus to a single backing store.
module cart_mbc1 #(
    parameter int ROM_AW = 21,
    parameter int RAM_AW = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       a,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              rd,
    input  logic              wr,
    input  logic              cs,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_ram,
    output logic [ROM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t state;

    logic [4:0]  bank1;
    logic [1:0]  bank2;
    logic        mode;
    logic        ram_en;
    logic        rd_q;
    logic        wr_q;
    logic        armed;
    logic [15:0] a_lat;

    logic              rd_s;
    logic              wr_s;
    logic              strobe;
    logic              rd_rise;
    logic              wr_rise;
    logic              in_rom;
    logic              in_ram;
    logic              ram_ok;
    logic              rd_valid;
    logic              reg_wr;
    logic              bad_rise;
    logic              launch;
    logic [20:0]       rom_full;
    logic [14:0]       ram_full;
    logic [ROM_AW-1:0] addr_n;

    // A simultaneous rd and wr is a write; armed masks the first cycle after
    // reset so a strobe already high at release is not seen as a new edge.
    always_comb begin
        rd_s     = cs & rd & ~wr;
        wr_s     = cs & wr;
        strobe   = cs & (rd | wr);
        rd_rise  = rd_s & ~rd_q & armed;
        wr_rise  = wr_s & ~wr_q & armed;
        in_rom   = ~a[15];
        in_ram   = (a[15:13] == 3'b101);
        ram_ok   = in_ram & ram_en;
        rd_valid = in_rom | ram_ok;
        reg_wr   = wr_rise & in_rom;
        bad_rise = (rd_rise & ~rd_valid) | (wr_rise & ~in_rom & ~ram_ok);

        if (a[14]) begin
            rom_full = {bank2, bank1, a[13:0]};
        end else begin
            rom_full = {(mode ? bank2 : 2'b00), 5'b0_0000, a[13:0]};
        end
        ram_full = {(mode ? bank2 : 2'b00), a[12:0]};

        if (in_ram) begin
            addr_n = ROM_AW'(RAM_AW'(ram_full));
        end else begin
            addr_n = ROM_AW'(rom_full);
        end

        launch = 1'b0;
        case (state)
            IDLE:    launch = (rd_rise & rd_valid) | (wr_rise & ram_ok);
            HOLD:    launch = strobe & rd_s & rd_valid & (a != a_lat);
            default: launch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bank1     <= 5'd1;
            bank2     <= '0;
            mode      <= 1'b0;
            ram_en    <= 1'b0;
            dout      <= '1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_ram   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            armed     <= 1'b0;
            a_lat     <= '0;
        end else begin
            rd_q  <= rd_s;
            wr_q  <= wr_s;
            armed <= 1'b1;

            if (reg_wr) begin
                case (a[14:13])
                    2'd0: ram_en <= (din[3:0] == 4'hA);
                    2'd1: bank1  <= (din[4:0] == 5'd0) ? 5'd1 : din[4:0];
                    2'd2: bank2  <= din[1:0];
                    2'd3: mode   <= din[0];
                    default: ;
                endcase
            end

            if (bad_rise) begin
                dout <= '1;
            end

            if (launch) begin
                state     <= REQ;
                mem_req   <= 1'b1;
                mem_we    <= wr_rise;
                mem_ram   <= in_ram;
                mem_addr  <= addr_n;
                mem_wdata <= din;
                a_lat     <= a;
            end else begin
                case (state)
                    // Address changes or strobe drops seen here are resolved from HOLD.
                    REQ: begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= HOLD;
                            if (!mem_we) begin
                                dout <= mem_rdata;
                            end
                        end
                    end
                    HOLD: begin
                        if (!strobe) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cart_mbc1.sv
// Self-checking bench for cart_mbc1: bus-level mapper model, per-cycle output
// checker with a randomised-latency backing store, directed and random traffic.
module tb_cart_mbc1;
    localparam int ROM_AW = 21;
    localparam int RAM_AW = 15;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic [15:0]       a     = '0;
    logic [7:0]        din   = '0;
    logic              rd    = 1'b0;
    logic              wr    = 1'b0;
    logic              cs    = 1'b0;
    logic [7:0]        dout;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ram;
    logic [ROM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = '0;
    logic              mem_ack   = 1'b0;

    cart_mbc1 #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout),
        .rd(rd), .wr(wr), .cs(cs),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ram(mem_ram),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Mapper register model
    int m_bank1 = 1;
    int m_bank2 = 0;
    int m_mode  = 0;
    int m_ramen = 0;

    function automatic int rom_map(input int ad);
        int hi;
        int r;
        hi = m_mode ? m_bank2 : 0;
        if (ad < 'h4000) r = hi * 'h80000 + ad;
        else             r = m_bank2 * 'h80000 + m_bank1 * 'h4000 + (ad - 'h4000);
        return r % (1 << ROM_AW);
    endfunction

    function automatic int ram_map(input int ad);
        int hi;
        hi = m_mode ? m_bank2 : 0;
        return (hi * 'h2000 + (ad - 'hA000)) % (1 << RAM_AW);
    endfunction

    task automatic model_reg_write(input int ad, input logic [7:0] d);
        case ((ad >> 13) & 3)
            0: m_ramen = ((d & 8'h0F) == 8'h0A) ? 1 : 0;
            1: m_bank1 = ((d % 32) == 0) ? 1 : int'(d % 32);
            2: m_bank2 = int'(d % 4);
            default: m_mode = int'(d % 2);
        endcase
    endtask

    task automatic model_reset();
        m_bank1 = 1; m_bank2 = 0; m_mode = 0; m_ramen = 0;
    endtask

    // Expected in-flight transaction, owned by the stimulus process
    logic       exp_valid = 1'b0;
    logic       exp_ram   = 1'b0;
    logic       exp_we    = 1'b0;
    int         exp_addr  = 0;
    logic [7:0] exp_wdata = '0;
    int         ff_epoch  = 0;
    int         ack_delay = 0;
    int         force_rdata = -1;

    task automatic set_exp(input logic ram, input logic we, input int ad, input logic [7:0] d);
        exp_ram = ram; exp_we = we; exp_addr = ad; exp_wdata = d; exp_valid = 1'b1;
    endtask

    // Checker and backing-store responder, owned by this process
    int         served    = 0;
    int         req_rises = 0;
    logic [7:0] exp_dout  = 8'hFF;
    logic [7:0] pend      = '0;
    bit         pend_v    = 0;
    int         ff_seen   = 0;
    logic       req_prev  = 1'b0;
    bit         resp_busy = 0;
    int         resp_cnt  = 0;

    always @(posedge clk) begin
        #2;
        if (pend_v) begin exp_dout = pend; pend_v = 0; end
        if (ff_seen != ff_epoch) begin exp_dout = 8'hFF; ff_seen = ff_epoch; end
        if (rst) begin exp_dout = 8'hFF; pend_v = 0; end
        check("dout", dout, exp_dout);
        if (!exp_valid) check("no_req", mem_req, 0);
        if (mem_req && exp_valid) begin
            check("mem_addr", mem_addr, exp_addr);
            check("mem_ram", mem_ram, exp_ram);
            check("mem_we", mem_we, exp_we);
            if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
        end
        if (mem_ack) check("req_fall", mem_req, 0);
        if (mem_req && !req_prev) req_rises++;
        req_prev = mem_req;

        if (mem_ack) begin
            mem_ack = 1'b0;
        end else begin
            if (!resp_busy && mem_req) begin
                resp_busy = 1;
                resp_cnt  = ack_delay;
            end
            if (resp_busy) begin
                if (resp_cnt == 0) begin
                    resp_busy = 0;
                    mem_ack   = 1'b1;
                    mem_rdata = (force_rdata >= 0) ? 8'(force_rdata) : 8'($urandom);
                    // An ack only counts if the request is still outstanding.
                    if (mem_req) begin
                        served++;
                        if (!mem_we) begin pend = mem_rdata; pend_v = 1; end
                    end
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    task automatic wait_served(input int target);
        int n;
        n = 0;
        while (served < target && n < 50) begin
            @(posedge clk); #3;
            n++;
        end
        check("served", served, target);
    endtask

    task automatic access(input int ad, input bit is_wr, input bit both,
                          input logic [7:0] d, input int hold, input int lit_addr);
        bit rom_sp;
        bit ram_sp;
        bit txn;
        int target;
        rom_sp = (ad < 'h8000);
        ram_sp = (ad >= 'hA000) && (ad < 'hC000);
        txn    = 0;
        @(negedge clk);
        if (is_wr) begin
            if (rom_sp) model_reg_write(ad, d);
            else if (ram_sp && m_ramen != 0) begin txn = 1; set_exp(1'b1, 1'b1, ram_map(ad), d); end
            else ff_epoch++;
        end else begin
            if (rom_sp) begin txn = 1; set_exp(1'b0, 1'b0, rom_map(ad), d); end
            else if (ram_sp && m_ramen != 0) begin txn = 1; set_exp(1'b1, 1'b0, ram_map(ad), d); end
            else ff_epoch++;
        end
        target = served + 1;
        a = 16'(ad); din = d; cs = 1'b1; rd = !is_wr || both; wr = is_wr;
        if (txn) begin
            @(posedge clk); #3;
            check("req_start", mem_req, 1);
            if (lit_addr >= 0) check("lit_addr", mem_addr, lit_addr);
            wait_served(target);
            exp_valid = 1'b0;
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int s0;
        int target;

        // Strobe already high across reset release must not start an access
        cs = 1'b1; rd = 1'b1; a = 16'h4000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #3;
        check("rst_dout", dout, 'hFF);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_ram", mem_ram, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        repeat (4) @(posedge clk);
        #3 check("rst_no_start", req_rises, 0);
        @(negedge clk); cs = 1'b0; rd = 1'b0;
        repeat (2) @(negedge clk);

        // RAM disabled, then enabled write
        access('hA000, 0, 0, 8'h00, 1, -1);
        check("ram_dis_ff", dout, 'hFF);
        check("ram_dis_noreq", req_rises, 0);
        access('h0000, 1, 0, 8'h0A, 0, -1);
        access('hB234, 1, 0, 8'h77, 0, 'h1234);

        // Bank1 zero maps to 1
        force_rdata = 'h5A;
        access('h2000, 1, 0, 8'h00, 0, -1);
        access('h4000, 0, 0, 8'h00, 1, 'h04000);
        force_rdata = -1;
        check("bank0_dout", dout, 'h5A);

        // Held write strobe updates once; held read issues one request
        access('h2000, 1, 0, 8'h05, 4, -1);
        r0 = req_rises;
        access('h4000, 0, 0, 8'h00, 6, 'h14000);
        check("held_rd_one_req", req_rises - r0, 1);

        // Mode 1 with full banks
        access('h2000, 1, 0, 8'h1F, 0, -1);
        access('h4000, 1, 0, 8'h03, 0, -1);
        access('h6000, 1, 0, 8'h01, 0, -1);
        access('h0123, 0, 0, 8'h00, 0, 'h180123);
        access('h7FFF, 0, 0, 8'h00, 0, 'h1FFFFF);

        // Strobe dropped while the request is pending
        ack_delay = 3;
        @(negedge clk);
        set_exp(1'b0, 1'b0, rom_map('h4000), 8'h00);
        r0 = req_rises; target = served + 1;
        a = 16'h4000; cs = 1'b1; rd = 1'b1;
        @(posedge clk); #3 check("drop_req", mem_req, 1);
        @(negedge clk); cs = 1'b0; rd = 1'b0;
        wait_served(target);
        exp_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("drop_one_req", req_rises - r0, 1);

        // Address changes during REQ and during HOLD
        @(negedge clk);
        set_exp(1'b0, 1'b0, rom_map('h4000), 8'h00);
        r0 = req_rises; target = served + 1;
        a = 16'h4000; cs = 1'b1; rd = 1'b1;
        @(posedge clk); #3 check("chg_req", mem_req, 1);
        @(negedge clk); a = 16'h4001;
        wait_served(target);
        exp_addr = rom_map('h4001); target++;
        wait_served(target);
        @(negedge clk); a = 16'h4002; exp_addr = rom_map('h4002); target++;
        wait_served(target);
        exp_valid = 1'b0;
        @(negedge clk); cs = 1'b0; rd = 1'b0;
        repeat (2) @(negedge clk);
        check("chg_reqs", req_rises - r0, 3);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            int kind;
            int ad;
            int hold;
            kind = $urandom_range(0, 5);
            hold = $urandom_range(0, 3);
            ack_delay = $urandom_range(0, 3);
            case (kind)
                0: begin
                    ad = $urandom_range(0, 'h7FFF);
                    access(ad, 1, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 1) != 0) ? 8'h0A : 8'($urandom), hold, -1);
                end
                1, 2: access($urandom_range(0, 'h7FFF), 0, 0, 8'($urandom), hold, -1);
                3: access($urandom_range('hA000, 'hBFFF), 0, 0, 8'($urandom), hold, -1);
                4: access($urandom_range('hA000, 'hBFFF), 1, 1'($urandom_range(0, 1)), 8'($urandom), hold, -1);
                default: begin
                    ad = ($urandom_range(0, 1) != 0) ? $urandom_range('h8000, 'h9FFF)
                                                     : $urandom_range('hC000, 'hFFFF);
                    access(ad, 1'($urandom_range(0, 1)), 0, 8'($urandom), hold, -1);
                end
            endcase
        end

        // Reset during a pending request with a late ack
        access('h0000, 1, 0, 8'h0A, 0, -1);
        access('h2000, 1, 0, 8'h07, 0, -1);
        access('h4000, 1, 0, 8'h02, 0, -1);
        access('h6000, 1, 0, 8'h01, 0, -1);
        ack_delay = 3;
        @(negedge clk);
        set_exp(1'b0, 1'b0, rom_map('h4000), 8'h00);
        s0 = served;
        a = 16'h4000; cs = 1'b1; rd = 1'b1;
        @(posedge clk); #3 check("rst_mid_req", mem_req, 1);
        @(negedge clk);
        rst = 1'b1; exp_valid = 1'b0; model_reset();
        #1;
        check("rst_drop_req", mem_req, 0);
        check("rst_mid_dout", dout, 'hFF);
        check("rst_mid_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0; cs = 1'b0; rd = 1'b0;
        repeat (6) @(negedge clk);
        check("late_ack_dout", dout, 'hFF);
        check("late_ack_ignored", served, s0);
        ack_delay = 1;
        access('h4000, 0, 0, 8'h00, 0, 'h04000);
        r0 = req_rises;
        access('hA000, 0, 0, 8'h00, 0, -1);
        check("rst_ram_dis_ff", dout, 'hFF);
        check("rst_ram_dis_noreq", req_rises - r0, 0);
        access('h4000, 1, 0, 8'h03, 0, -1);
        access('h0123, 0, 0, 8'h00, 0, 'h00123);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
